// File: rtl/temp_sample_sequencer.sv
// Temperature sample sequencer: paces DRP reads of the SYSMON temperature
// register, recovers from missing read-data, and averages 2^AVG_LOG2 samples
// into a raw code for the fan controller.
module temp_sample_sequencer #(
   parameter int unsigned SAMPLE_DIV = 100000,
   parameter logic [6:0]  TEMP_ADDR  = 7'h00,
   parameter int unsigned TIMEOUT    = 255,
   parameter int unsigned AVG_LOG2   = 2
) (
   input  logic        clk_in_100,
   input  logic        rst_in,
   input  logic        enable_in,
   output logic        drp_den_out,
   output logic [6:0]  drp_daddr_out,
   output logic        drp_dwe_out,
   output logic [15:0] drp_di_out,
   input  logic [15:0] drp_do_in,
   input  logic        drp_drdy_in,
   output logic [15:0] raw_temp_out,
   output logic        raw_temp_valid_out,
   output logic [7:0]  timeout_cnt_out,
   output logic        busy_out
);

   localparam int unsigned TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
   localparam int unsigned ACC_W  = 16 + AVG_LOG2;
   localparam int unsigned CNT_W  = AVG_LOG2 + 1;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t            state, state_nxt;
   logic [TICK_W-1:0] tick_cnt;
   logic              tick;
   logic [WAIT_W-1:0] wait_cnt;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  acc_sum;
   logic [CNT_W-1:0]  sample_cnt;
   logic              drop_avg;   // enable fell while a read was in flight
   logic              capture;
   logic              timed_out;

   // Write side of the DRP is never used; only the temperature register is read.
   assign drp_daddr_out = TEMP_ADDR;
   assign drp_dwe_out   = 1'b0;
   assign drp_di_out    = '0;

   assign tick    = enable_in && (tick_cnt == TICK_LAST);
   // Accumulator is wide enough for 2^AVG_LOG2 full-scale samples, so no overflow.
   assign acc_sum = acc + ACC_W'(drp_do_in);

   // Free-running sample tick divider, parked at zero while disabled.
   always_ff @(posedge clk_in_100) begin
      if (rst_in || !enable_in)
         tick_cnt <= '0;
      else if (tick_cnt == TICK_LAST)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + TICK_W'(1);
   end

   // FSM state register.
   always_ff @(posedge clk_in_100) begin
      if (rst_in)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state decode plus DRP strobe and completion events.
   always_comb begin
      state_nxt   = state;
      drp_den_out = 1'b0;
      busy_out    = (state != IDLE);
      capture     = 1'b0;
      timed_out   = 1'b0;
      case (state)
         IDLE: if (tick) state_nxt = REQ;
         REQ: begin
            drp_den_out = 1'b1;
            state_nxt   = WAIT;
         end
         WAIT: begin
            if (drp_drdy_in) begin
               capture   = 1'b1;
               state_nxt = IDLE;
            end else if (wait_cnt == WAIT_LAST) begin
               timed_out = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Cycles spent in WAIT; cleared everywhere else (including the REQ cycle).
   always_ff @(posedge clk_in_100) begin
      if (rst_in || state != WAIT)
         wait_cnt <= '0;
      else
         wait_cnt <= wait_cnt + WAIT_W'(1);
   end

   // Averaging datapath, output register and timeout accounting.
   always_ff @(posedge clk_in_100) begin
      if (rst_in) begin
         raw_temp_out       <= 16'hFFFF;
         raw_temp_valid_out <= 1'b0;
         timeout_cnt_out    <= '0;
         acc                <= '0;
         sample_cnt         <= '0;
         drop_avg           <= 1'b0;
      end else begin
         raw_temp_valid_out <= 1'b0;

         if (timed_out && timeout_cnt_out != 8'hFF)
            timeout_cnt_out <= timeout_cnt_out + 8'd1;

         // Disable while idle flushes at once; while busy it is remembered
         // and applied when the read completes.
         if (state == IDLE) begin
            drop_avg <= 1'b0;
            if (!enable_in) begin
               acc        <= '0;
               sample_cnt <= '0;
            end
         end else if (!enable_in) begin
            drop_avg <= 1'b1;
         end

         if (capture || timed_out) begin
            if (drop_avg || !enable_in) begin
               acc        <= '0;
               sample_cnt <= '0;
            end else if (capture) begin
               if (sample_cnt == CNT_LAST) begin
                  raw_temp_out       <= acc_sum[ACC_W-1:AVG_LOG2];
                  raw_temp_valid_out <= 1'b1;
                  acc                <= '0;
                  sample_cnt         <= '0;
               end else begin
                  acc        <= acc_sum;
                  sample_cnt <= sample_cnt + CNT_W'(1);
               end
            end
         end
      end
   end

endmodule
